// File: rtl/sram_fifo_ctrl_if.sv
// Valid/ready push and pop stream between a producer/consumer pair and sram_fifo_ctrl.
interface sram_fifo_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO sequencer around an external 1R/1W async-read SRAM.
// Define SRAM_FIFO_CTRL_OUTREG_EN to add a one-entry registered output stage.
module sram_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned DATA_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    sram_fifo_ctrl_if.slave               stream,
    output logic [$clog2(DATA_DEPTH):0]   count,
    output logic [$clog2(DATA_DEPTH)-1:0] sram_addrw,
    output logic [$clog2(DATA_DEPTH)-1:0] sram_addrr,
    output logic                          sram_ce,
    output logic                          sram_we,
    output logic [DATA_WIDTH-1:0]         sram_dataw,
    input  logic [DATA_WIDTH-1:0]         sram_datar
);
    localparam int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] wptr;
    logic [ADDR_WIDTH:0] rptr;
    logic [ADDR_WIDTH:0] wptr_nxt;
    logic [ADDR_WIDTH:0] rptr_nxt;
    logic [ADDR_WIDTH:0] count_nxt;
    logic                clear;
    logic                empty;
    logic                full;
    logic                push;
    logic                pop;
    logic                fetch;

    assign clear = !rst_n || flush;
    assign empty = (wptr == rptr);
    assign full  = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);

    assign stream.in_ready = !full;
    // Gating by clear keeps the SRAM untouched in a reset/flush cycle.
    assign push = stream.in_valid && !full && !clear;

    assign sram_ce    = 1'b1;
    assign sram_we    = push;
    assign sram_addrw = wptr[ADDR_WIDTH-1:0];
    assign sram_dataw = stream.in_data;
    assign sram_addrr = rptr[ADDR_WIDTH-1:0];

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (push) begin
            wptr_nxt = wptr + PTR_ONE;
        end
        if (fetch) begin
            rptr_nxt = rptr + PTR_ONE;
        end
    end

`ifdef SRAM_FIFO_CTRL_OUTREG_EN
    logic                  oreg_valid;
    logic                  oreg_valid_nxt;
    logic [DATA_WIDTH-1:0] oreg;

    // The SRAM head moves into oreg whenever oreg is free or being consumed.
    assign pop            = oreg_valid && stream.out_ready;
    assign fetch          = !empty && (!oreg_valid || pop);
    assign oreg_valid_nxt = fetch || (oreg_valid && !pop);
    assign stream.out_valid = oreg_valid;
    assign stream.out_data  = oreg;
    assign count_nxt = (wptr_nxt - rptr_nxt) + {{ADDR_WIDTH{1'b0}}, oreg_valid_nxt};

    always_ff @(posedge clk) begin
        if (clear) begin
            oreg_valid <= 1'b0;
            oreg       <= '0;
        end else begin
            oreg_valid <= oreg_valid_nxt;
            if (fetch) begin
                oreg <= sram_datar;
            end
        end
    end
`else
    assign pop   = !empty && stream.out_ready;
    assign fetch = pop;
    assign stream.out_valid = !empty;
    assign stream.out_data  = sram_datar;
    assign count_nxt = wptr_nxt - rptr_nxt;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            count <= count_nxt;
        end
    end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Sequencing controller that turns a 1-read/1-write async-read SRAM macro into a synchronous valid/ready FIFO.
- Owns the read/write pointers, occupancy count and full/empty logic, and drives the SRAM write/read ports.
- Used as the generic queue for pipeline buffers (fetch queue, store buffer, writeback queues) next to an externally instantiated SRAM.

Parameters:
- DATA_WIDTH, 64, entry width in bits.
- DATA_DEPTH, 16, number of SRAM entries; must be a power of two, at least 2.
- ADDR_WIDTH, $clog2(DATA_DEPTH), localparam; SRAM address width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of all contents.
- in_valid  in  1  producer has data.
- in_ready  out  1  FIFO can accept.
- in_data  in  DATA_WIDTH  push data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_data  out  DATA_WIDTH  head data.
- count  out  ADDR_WIDTH+1  occupancy, 0..capacity.
- sram_addrw  out  ADDR_WIDTH  SRAM write address.
- sram_addrr  out  ADDR_WIDTH  SRAM read address.
- sram_ce  out  1  SRAM enable; tied 1.
- sram_we  out  1  SRAM write strobe.
- sram_dataw  out  DATA_WIDTH  SRAM write data.
- sram_datar  in  DATA_WIDTH  SRAM async read data, same cycle as sram_addrr.

Behaviour:
- Pointers wptr and rptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
  - empty = (wptr == rptr).
  - full = (low bits equal) and (MSBs differ).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- sram_we = push (combinational); sram_addrw = wptr[ADDR_WIDTH-1:0]; sram_dataw = in_data.
- sram_addrr = rptr[ADDR_WIDTH-1:0]; out_data = sram_datar (combinational, zero-latency head).
- in_ready = !full; out_valid = !empty.
  - No write-through bypass: data pushed in cycle N is first visible on out_data in cycle N+1.
- On push, wptr increments; on pop, rptr increments. Both wrap naturally modulo 2*DATA_DEPTH.
- Simultaneous push and pop:
  - When neither full nor empty: both pointers advance and count is unchanged.
  - When full: in_ready=0, so only the pop occurs; a push is accepted the following cycle.
  - When empty: out_valid=0, so only the push occurs.
- count = wptr - rptr, registered alongside the pointers.
- Reset (rst_n=0 at posedge) and flush=1 both behave as follows:
  - wptr = rptr = 0, count = 0, out_valid = 0, in_ready = 1.
  - SRAM contents are untouched.
  - sram_we is forced 0 in the cycle flush or reset is asserted, so no write occurs in that cycle.
  - Reset has priority over flush; flush has priority over push and pop.
- Reset or flush mid-stream discards all entries, including any handshake presented in that cycle.
- Reset values: in_ready=1, out_valid=0, count=0, sram_we=0, sram_ce=1, sram_addrw=0, sram_addrr=0.
- Inputs are sampled only at posedge clk; the block holds no combinational path from out_ready to in_ready.

Optional Feature:
- Macro SRAM_FIFO_CTRL_OUTREG_EN.
- Defined: adds a one-entry registered output stage (oreg, oreg_valid) between the SRAM read port and out_data/out_valid.
  - out_data = oreg; out_valid = oreg_valid.
  - Prefetch: when the SRAM is non-empty and (oreg_valid=0 or pop), oreg loads sram_datar and rptr increments.
  - Capacity becomes DATA_DEPTH+1; count includes the oreg entry; in_ready stays !full on the SRAM pointers only.
  - Push-to-out_valid latency is 2 cycles; sustained throughput is 1 per cycle.
  - Reset and flush clear oreg_valid to 0 and oreg to 0.
- Undefined: combinational head as described under Behaviour; capacity DATA_DEPTH; latency 1 cycle.

Test Plan:
- DEPTH=4. Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0 -> count=4, in_ready=0 from the cycle after the fourth push; out_data=0x11.
- From full, out_ready=1 and in_valid=1 with 0x55 -> the 0x55 push is rejected in that cycle and count drops to 3. Hold out_ready=1 and keep in_valid=1 -> 0x55 is accepted next cycle, count stays 3. Drain order is 0x22,0x33,0x44,0x55.
- Continuous push and pop of 20 items, 0x00..0x13 -> output order identical, pointers wrap through 0 at least twice, count never exceeds 1 (2 with OUTREG).
- Empty FIFO, push 0xAB in cycle N with out_ready=1 -> out_valid=0 in cycle N, out_valid=1 and out_data=0xAB in cycle N+1, then empty.
- Fill with 3 entries, assert flush with in_valid=1 (0x77) -> next cycle count=0, out_valid=0, no SRAM write seen for 0x77. Repeat with rst_n=0 -> same result.
- With SRAM_FIFO_CTRL_OUTREG_EN: push 5 items into DEPTH=4 with out_ready=0 -> 5 accepted (count=5), the 6th is stalled; drain returns all 5 in order.
